// File: rtl/int4_mac_acc_ctrl_if.sv
// Handshake bundle between the accumulation controller, the INT4 MAC
// datapath and the downstream consumer of finished dot products.
// The master side is the controller; the slave side is the environment
// (MAC operand source, MAC datapath and result sink).
interface int4_mac_acc_ctrl_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic             mac_en;
  logic [ACC_W-1:0] mac_sum;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    input  in_valid,
    output in_ready,
    output mac_en,
    input  mac_sum,
    output acc_out,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    output in_valid,
    input  in_ready,
    input  mac_en,
    output mac_sum,
    input  acc_out,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/int4_mac_acc_ctrl.sv
// Sequencer and running-sum register wrapped around the combinational
// INT4 MAC. The partial sum lives here: it feeds the MAC from acc_out and
// takes mac_sum back on every accepted operand beat. After len beats the
// final sum is held on a valid/ready result port. All outputs are flops,
// so there is no combinational path from any input to any output.
module int4_mac_acc_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             clear,
  int4_mac_acc_ctrl_if.master bus,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               beat_accept;
  logic               last_beat;

  assign beat_accept = bus.in_valid && in_ready_q;
  // len_q is never zero while in ACCUM, so len_q-1 cannot underflow there.
  assign last_beat   = (cnt_q == (len_q - LEN_W'(1)));

  // Next-state and datapath register update; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    if (clear) begin
      state_d    = ST_IDLE;
      acc_d      = {ACC_W{1'b0}};
      cnt_d      = {LEN_W{1'b0}};
      out_data_d = {ACC_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len != {LEN_W{1'b0}}) begin
              len_d   = len;
              acc_d   = {ACC_W{1'b0}};
              cnt_d   = {LEN_W{1'b0}};
              state_d = ST_ACCUM;
            end else begin
              out_data_d = {ACC_W{1'b0}};
              state_d    = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (beat_accept) begin
            acc_d = bus.mac_sum;
            cnt_d = cnt_q + LEN_W'(1);
            if (last_beat) begin
              out_data_d = bus.mac_sum;
              state_d    = ST_DONE;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they can be registered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      ST_ACCUM: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // FSM state, running sum, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= {LEN_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      out_data_q  <= {ACC_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mac_en    = in_ready_q;
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign beat_cnt      = cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_int4_mac_acc_ctrl.sv
// Bench for int4_mac_acc_ctrl with a MAC stub that adds a programmable
// increment to acc_out. Expected results go into a scoreboard when a job
// is launched and are popped when the result handshake completes.
module tb_int4_mac_acc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        clear;
  logic [7:0]  beat_cnt;
  logic        busy;
  logic [23:0] stub_inc;

  int n_checks;
  int n_errors;
  logic [23:0] sb[$];
  logic [23:0] last_exp;

  int4_mac_acc_ctrl_if #(.ACC_W(24)) ifc ();

  assign ifc.mac_sum = ifc.acc_out + stub_inc;

  int4_mac_acc_ctrl #(.ACC_W(24), .LEN_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .clear    (clear),
    .bus      (ifc),
    .beat_cnt (beat_cnt),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every completed handshake pops one expected sum.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        chk("out_data", 32'(ifc.out_data), 32'(sb.pop_front()));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Launch a job from IDLE and feed the valid pattern; leaves the result held.
  task automatic run_job(input logic [7:0] l, input logic [23:0] inc,
                         input logic [15:0] pat, input int npat);
    logic [23:0] exp_acc;
    logic [23:0] exp_fin;
    int beats;
    stub_inc = inc;
    exp_fin  = 24'd0;
    for (int k = 0; k < int'(l); k++) exp_fin = exp_fin + inc;
    sb.push_back(exp_fin);
    last_exp = exp_fin;
    start = 1'b1;
    len   = l;
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    len   = ~l;
    beats = 0;
    exp_acc = 24'd0;
    chk("start_in_ready", 32'(ifc.in_ready), 32'(l != 8'd0));
    chk("start_out_valid", 32'(ifc.out_valid), 32'(l == 8'd0));
    chk("start_busy", 32'(busy), 32'd1);
    if (l != 8'd0) begin
      chk("start_acc", 32'(ifc.acc_out), 32'd0);
      chk("start_cnt", 32'(beat_cnt), 32'd0);
    end else begin
      chk("len0_out_data", 32'(ifc.out_data), 32'd0);
    end
    for (int i = 0; i < npat; i++) begin
      ifc.in_valid = pat[i];
      @(posedge clk); #1;
      if (pat[i] && beats < int'(l)) begin
        beats++;
        exp_acc = exp_acc + inc;
      end
      chk("beat_acc", 32'(ifc.acc_out), 32'(exp_acc));
      chk("beat_cnt", 32'(beat_cnt), 32'(beats));
      chk("beat_out_valid", 32'(ifc.out_valid), 32'(beats == int'(l)));
      chk("beat_in_ready", 32'(ifc.in_ready), 32'(beats < int'(l)));
      chk("beat_mac_en", 32'(ifc.mac_en), 32'(beats < int'(l)));
    end
    ifc.in_valid = 1'b0;
  endtask

  // Accept the held result and confirm return to IDLE with data retained.
  task automatic finish_job();
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk("fin_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("fin_out_data_kept", 32'(ifc.out_data), 32'(last_exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    len   = 8'd0;
    clear = 1'b0;
    stub_inc = 24'd0;
    last_exp = 24'd0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_mac_en", 32'(ifc.mac_en), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acc", 32'(ifc.acc_out), 32'd0);
    chk("rst_out_data", 32'(ifc.out_data), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic job: four beats of +5.
    run_job(8'd4, 24'd5, 16'h000F, 4);
    chk("job1_cnt", 32'(beat_cnt), 32'd4);
    finish_job();

    // Stalled input: pattern 1,0,0,1,1 for three beats.
    run_job(8'd3, 24'd7, 16'h0019, 5);
    finish_job();

    // Positive wrap without saturation.
    run_job(8'd2, 24'h7FFFFF, 16'h0003, 2);
    finish_job();

    // Negative increments, then result backpressure with an ignored start.
    run_job(8'd3, 24'hFFFFFD, 16'h0007, 3);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd9;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("bp_out_data", 32'(ifc.out_data), 32'(last_exp));
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_cnt", 32'(beat_cnt), 32'd3);
    end
    start = 1'b0;
    finish_job();

    // Zero-length job.
    run_job(8'd0, 24'd3, 16'h0000, 0);
    finish_job();

    // Clear in the middle of accumulation.
    stub_inc = 24'd1;
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ifc.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_pre_cnt", 32'(beat_cnt), 32'd2);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_acc", 32'(ifc.acc_out), 32'd0);
    chk("clr_cnt", 32'(beat_cnt), 32'd0);
    chk("clr_out_data", 32'(ifc.out_data), 32'd0);
    chk("clr_in_ready", 32'(ifc.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("clr_no_out_valid", 32'(ifc.out_valid), 32'd0);
    end

    // Asynchronous reset between clock edges.
    stub_inc = 24'd2;
    start = 1'b1;
    len   = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    ifc.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_pre_acc", 32'(ifc.acc_out), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", 32'(ifc.acc_out), 32'd0);
    chk("arst_cnt", 32'(beat_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("arst_mac_en", 32'(ifc.mac_en), 32'd0);
    chk("arst_out_valid", 32'(ifc.out_valid), 32'd0);
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery job after reset.
    run_job(8'd3, 24'h000010, 16'h0007, 3);
    finish_job();

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
